// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: issues pipelined imem requests, buffers in-order
// responses in a small queue and presents {pc, instr} to decode.
module fetch_queue_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter int unsigned      DEPTH        = 4,
  parameter int unsigned      MAX_INFLIGHT = 2,
  parameter logic [XLEN-1:0]  RESET_PC     = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_resp_valid,
  input  logic [XLEN-1:0]            imem_resp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int unsigned OW = $clog2(DEPTH+1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT+1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic [IW-1:0]   drop_q, drop_d;
  logic [OW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic [IW-1:0]   live;
  logic            accept, resp_hit, keep, pop;
  logic [XLEN-1:0] redirect_aligned;

  always_comb begin
    live             = inflight_q - drop_q;
    redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    // Credit check counts queued entries plus live requests so every kept
    // response is guaranteed a slot, even when the queue is full and popping.
    imem_req_valid   = !rst && !redirect_valid
                       && (32'(inflight_q) < MAX_INFLIGHT)
                       && ((32'(count_q) + 32'(live)) < DEPTH);
    imem_req_addr    = fetch_pc_q;
    accept           = imem_req_valid && imem_req_ready;
    resp_hit         = imem_resp_valid && (inflight_q != '0);
    keep             = resp_hit && (drop_q == '0) && !redirect_valid;
    out_valid        = (count_q != '0);
    pop              = out_valid && out_ready && !redirect_valid;
    out_pc           = out_valid ? pc_mem_q[head_q]    : '0;
    out_instr        = out_valid ? instr_mem_q[head_q] : '0;
    occupancy        = count_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (accept && !resp_hit)      inflight_d = inflight_q + IW'(1);
    else if (!accept && resp_hit) inflight_d = inflight_q - IW'(1);

    if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (keep) begin
      resp_pc_d = resp_pc_q + XLEN'(4);
      tail_d    = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);

    if (keep && !pop)      count_d = count_q + OW'(1);
    else if (!keep && pop) count_d = count_q - OW'(1);

    if (resp_hit && (drop_q != '0)) drop_d = drop_q - IW'(1);

    // Everything still outstanding after this cycle's accounting becomes stale.
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_d     = inflight_d;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && keep) begin
      pc_mem_q[tail_q]    <= resp_pc_q;
      instr_mem_q[tail_q] <= imem_resp_data;
    end
  end

endmodule
